// File: rtl/neuron_mac.sv
// ---------------------------------------------------------------------------
// NeuronMac -- single-neuron multiply-accumulate with saturating output.
//
// Accepts N_INPUTS (x, weight) beats over a valid/ready handshake. The bias
// presented on the first beat seeds the accumulator. Each product is the full
// signed x*weight rescaled back to the Q(DATA_W-FRAC_W).FRAC_W input format by
// a flooring arithmetic shift. After the last beat the accumulated sum is
// saturated to DATA_W bits and held on the output handshake until taken.
//
// Optional feature: define NEURON_MAC_RELU_EN to clamp negative results to 0
// (out_sat still reports whether the signed sum was clipped).
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_valid   x / weight / bias are valid
//   in_ready   block accepts a beat (high while accumulating)
//   x          signed activation, DATA_W bits
//   weight     signed weight, DATA_W bits
//   bias       signed bias, sampled on the first beat of a neuron only
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   out_data   signed saturated neuron result, DATA_W bits
//   out_sat    out_data was clipped
// ---------------------------------------------------------------------------
module neuron_mac #(
    parameter int DATA_W   = 8,
    parameter int FRAC_W   = 7,
    parameter int N_INPUTS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] weight,
    input  logic [DATA_W-1:0] bias,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sat
);

    // Accumulator has headroom for N_INPUTS products plus the bias.
    localparam int ACC_W  = DATA_W + 1 + $clog2(N_INPUTS) + 1;
    localparam int CNT_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam int PROD_W = 2 * DATA_W;
    localparam int WIDE_W = PROD_W + ACC_W;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUTS - 1);

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

    typedef enum logic [0:0] {
        ACC = 1'b0,
        OUT = 1'b1
    } state_t;

    state_t state;
    state_t next_state;

    logic [CNT_W-1:0]        cnt;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] bias_ext;
    logic [PROD_W-1:0]       x_ext;
    logic [PROD_W-1:0]       w_ext;
    logic [PROD_W-1:0]       prod_full;
    logic signed [WIDE_W-1:0] prod_wide;
    logic                    accept;
    logic                    last_beat;
    logic [DATA_W-1:0]       sat_val;
    logic                    clip;

    // Sign-extending both operands to 2*DATA_W lets a plain unsigned multiply
    // produce the exact signed product in its low 2*DATA_W bits.
    assign x_ext     = {{DATA_W{x[DATA_W-1]}}, x};
    assign w_ext     = {{DATA_W{weight[DATA_W-1]}}, weight};
    assign prod_full = x_ext * w_ext;

    // Widen before the arithmetic shift so the shift floors toward -inf and
    // the truncation to ACC_W keeps the sign.
    assign prod_wide = {{ACC_W{prod_full[PROD_W-1]}}, prod_full};
    assign prod_ext  = ACC_W'(prod_wide >>> FRAC_W);

    // Bias is already in output scale, so it only needs sign extension.
    assign bias_ext  = {{(ACC_W - DATA_W){bias[DATA_W-1]}}, bias};

    assign accept    = in_valid & in_ready;
    assign last_beat = (cnt == LAST_CNT);

    // State register for the accumulate / present-result handshake FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACC;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs. The input side is closed while a
    // result is pending, which is what makes in_valid in OUT harmless.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ACC: begin
                in_ready = 1'b1;
                if (in_valid && last_beat) begin
                    next_state = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = ACC;
                end
            end
            default: begin
                next_state = ACC;
            end
        endcase
    end

    // Beat counter and accumulator. The first beat reloads rather than adds,
    // so a discarded or transferred result never leaks into the next neuron.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            acc <= '0;
        end else if (accept) begin
            if (cnt == '0) begin
                acc <= bias_ext + prod_ext;
            end else begin
                acc <= acc + prod_ext;
            end
            if (last_beat) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Saturate the accumulator to DATA_W. acc is frozen while in OUT, so the
    // outputs stay stable until the consumer takes them.
    always_comb begin
        sat_val = acc[DATA_W-1:0];
        clip    = 1'b0;
        if (acc > SAT_MAX) begin
            sat_val = {1'b0, {(DATA_W - 1){1'b1}}};
            clip    = 1'b1;
        end else if (acc < SAT_MIN) begin
            sat_val = {1'b1, {(DATA_W - 1){1'b0}}};
            clip    = 1'b1;
        end
    end

    // Output stage: optional ReLU clamps negative results to zero while the
    // clip flag keeps reporting the signed saturation.
    always_comb begin
        out_sat  = clip;
`ifdef NEURON_MAC_RELU_EN
        out_data = sat_val;
        if (sat_val[DATA_W-1]) begin
            out_data = '0;
        end
`else
        out_data = sat_val;
`endif
    end

endmodule
